// File: rtl/trigger_pkg.sv
// trigger_pkg: shared types and constants for the push-button trigger path.
//   press_state_t : debounce / pulse FSM states
//   arm_state_t   : software-handshake FSM states
//   T0_INDEX      : register-file index of t0 (x5), the register the
//                   trigger sets and whose read tap feeds t0_in
package trigger_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DB_PRESS   = 3'd1,
    FIRE       = 3'd2,
    HELD       = 3'd3,
    DB_RELEASE = 3'd4
  } press_state_t;

  typedef enum logic [1:0] {
    ARMED      = 2'd0,
    WAIT_SET   = 2'd1,
    WAIT_CLEAR = 2'd2
  } arm_state_t;

  localparam int T0_INDEX = 5;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for asynchronous board inputs.
//   clk   : destination clock
//   rst   : async active-high reset, clears both stages
//   d     : asynchronous input bits (WIDTH)
//   q     : synchronized output bits (WIDTH)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Stage 0 may go metastable; stage 1 gives it a full cycle to settle.
  logic [1:0][WIDTH-1:0] pipe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      pipe[1] <= pipe[0];
    end
  end

  assign q = pipe[1];

endmodule

// File: rtl/trigger_source.sv
// trigger_source: debounces a push button into a single-cycle pulse that
// sets t0 (x5), then holds off further pulses until software has seen t0
// set and cleared it again.
//   clk      : system clock
//   rst      : async active-high reset; abandons any press or pending event
//   btn_in   : raw button level, active high, asynchronous
//   t0_in    : live read tap of register x5
//   trigger  : one-cycle pulse into the register file's t0 write
//   busy     : waiting for software to consume the last event
//   drop_cnt : saturating count of accepted presses suppressed while busy
module trigger_source
  import trigger_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_WIDTH       = $clog2(DEBOUNCE_CYCLES),
  parameter int DATA_WIDTH      = 32,
  parameter int DROP_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_in,
  input  logic [DATA_WIDTH-1:0] t0_in,
  output logic                  trigger,
  output logic                  busy,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                  btn_s;
  press_state_t          state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  arm_state_t            arm_q, arm_d;
  logic [DROP_WIDTH-1:0] drop_q;
  logic                  drop_inc;
  logic                  t0_set, t0_clr;

  sync_2ff #(.WIDTH(1)) u_btn_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  assign t0_set = (t0_in == DATA_WIDTH'(1));
  assign t0_clr = (t0_in == '0);

  // Press FSM: the counter is shared by press and release debounce since
  // the two phases never overlap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    drop_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (btn_s) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end
      DB_PRESS: begin
        if (!btn_s) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          // Registered arm state decides: a re-arm landing on this same
          // edge is too late and the press counts as dropped.
          if (arm_q == ARMED) begin
            state_d = FIRE;
          end else begin
            state_d  = HELD;
            drop_inc = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIRE: state_d = HELD;
      HELD: begin
        if (!btn_s) begin
          state_d = DB_RELEASE;
          cnt_d   = '0;
        end
      end
      DB_RELEASE: begin
        if (btn_s) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Arm FSM: leaves ARMED as the FIRE cycle ends. WAIT_SET absorbs the
  // register write latency so a stale t0==0 is not mistaken for a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) arm_q <= ARMED;
    else     arm_q <= arm_d;
  end

  always_comb begin
    arm_d = arm_q;
    unique case (arm_q)
      ARMED:      if (state_q == FIRE) arm_d = WAIT_SET;
      WAIT_SET:   if (t0_set)          arm_d = WAIT_CLEAR;
      WAIT_CLEAR: if (t0_clr)          arm_d = ARMED;
      default:                         arm_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          drop_q <= '0;
    else if (drop_inc && drop_q != '1) drop_q <= drop_q + 1'b1;
  end

  assign trigger  = (state_q == FIRE);
  assign busy     = (arm_q != ARMED);
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_trigger_source.sv
// tb_trigger_source: directed bench for trigger_source with DEBOUNCE_CYCLES=4.
// Inputs are driven and outputs sampled on the falling edge.
module tb_trigger_source;

  localparam int DB = 4;

  logic        clk;
  logic        rst;
  logic        btn_in;
  logic [31:0] t0_in;
  logic        trigger;
  logic        busy;
  logic [7:0]  drop_cnt;

  int n_chk;
  int n_err;
  int pulse_cnt;
  int p0;

  trigger_source #(
    .DEBOUNCE_CYCLES (DB),
    .DATA_WIDTH      (32),
    .DROP_WIDTH      (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .t0_in    (t0_in),
    .trigger  (trigger),
    .busy     (busy),
    .drop_cnt (drop_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every cycle in which trigger is high.
  always @(posedge clk) begin
    #1;
    if (trigger) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hi, input int lo);
    btn_in = 1'b1;
    tick(hi);
    btn_in = 1'b0;
    tick(lo);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0; n_err = 0; pulse_cnt = 0;
    rst = 1'b1; btn_in = 1'b1; t0_in = '0;

    // 1. reset with button held, then latency of the first pulse
    tick(3);
    chk("rst_trigger", {31'd0, trigger}, 32'd0);
    chk("rst_busy",    {31'd0, busy},    32'd0);
    chk("rst_drop",    {24'd0, drop_cnt}, 32'd0);
    rst = 1'b0;
    for (int j = 0; j < DB + 2; j++) begin
      tick(1);
      chk("pre_pulse_trig", {31'd0, trigger}, 32'd0);
      chk("pre_pulse_busy", {31'd0, busy},    32'd0);
    end
    tick(1);
    chk("pulse_edge", {31'd0, trigger}, 32'd1);
    tick(1);
    chk("pulse_one_cycle", {31'd0, trigger}, 32'd0);
    chk("busy_after_fire", {31'd0, busy},    32'd1);
    chk("pulse_count1", pulse_cnt, 32'd1);

    // handshake: t0 set the cycle after the pulse, cleared 20 cycles later
    t0_in  = 32'd1;
    btn_in = 1'b0;
    tick(20);
    t0_in = 32'd0;
    chk("busy_wait_clear", {31'd0, busy}, 32'd1);
    tick(1);
    chk("busy_rearm", {31'd0, busy}, 32'd0);

    // 2. glitch of DB-1 cycles
    p0 = pulse_cnt;
    press(DB - 1, 12);
    chk("glitch_pulses", pulse_cnt - p0, 32'd0);
    chk("glitch_drop",   {24'd0, drop_cnt}, 32'd0);
    chk("glitch_busy",   {31'd0, busy},     32'd0);

    // 3. long hold gives one pulse
    p0 = pulse_cnt;
    btn_in = 1'b1;
    tick(50);
    chk("hold_pulses", pulse_cnt - p0, 32'd1);
    chk("hold_busy",   {31'd0, busy},  32'd1);
    btn_in = 1'b0;
    tick(10);

    // 4. handshake then second press
    t0_in = 32'd1;
    tick(1);
    t0_in = 32'd0;
    chk("hs_busy_hold", {31'd0, busy}, 32'd1);
    tick(1);
    chk("hs_busy_fall", {31'd0, busy}, 32'd0);
    p0 = pulse_cnt;
    press(10, 10);
    chk("second_pulse", pulse_cnt - p0, 32'd1);
    chk("second_busy",  {31'd0, busy},  32'd1);

    // 5. drops while software holds t0 set
    t0_in = 32'd1;
    tick(2);
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) press(8, 8);
    chk("drop_pulses", pulse_cnt - p0, 32'd0);
    chk("drop_3",      {24'd0, drop_cnt}, 32'd3);
    chk("drop_busy",   {31'd0, busy},     32'd1);
    for (int i = 0; i < 300; i++) press(8, 8);
    chk("drop_sat",    {24'd0, drop_cnt}, 32'd255);
    chk("drop_pulses2", pulse_cnt - p0, 32'd0);
    t0_in = 32'd0;
    tick(1);
    chk("sat_rearm_busy", {31'd0, busy},     32'd0);
    chk("sat_rearm_drop", {24'd0, drop_cnt}, 32'd255);
    p0 = pulse_cnt;
    press(10, 10);
    chk("post_sat_pulse", pulse_cnt - p0, 32'd1);
    chk("post_sat_busy",  {31'd0, busy},  32'd1);

    // 6. async reset mid-debounce, between clock edges
    btn_in = 1'b1;
    tick(4);
    #2 rst = 1'b1;
    #1;
    chk("async_trigger", {31'd0, trigger},  32'd0);
    chk("async_busy",    {31'd0, busy},     32'd0);
    chk("async_drop",    {24'd0, drop_cnt}, 32'd0);
    p0 = pulse_cnt;
    @(negedge clk);
    rst = 1'b0;
    tick(12);
    chk("post_rst_pulse", pulse_cnt - p0, 32'd1);
    chk("post_rst_drop",  {24'd0, drop_cnt}, 32'd0);
    btn_in = 1'b0;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
